// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction-fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

    // Canonical no-op (addi x0, x0, 0) used to fill a squashed IF/ID slot
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Width of the optional performance counters
    localparam int CNT_W = 16;

    // Fetch controller state
    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/fetch_pc_ctrl_ifid_reg.sv
// ============================================================================
//  Module      : ifid_reg
//  Description : IF/ID pipeline register with flush / load / hold controls.
//                Flush (or reset) installs a NOP with valid cleared; load
//                captures the fetched PC and word; otherwise every bit holds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifid_reg
    import fetch_pkg::*;
#(
    parameter int PC_W = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic            i_load,
    input  logic [PC_W-1:0] i_pc,
    input  logic [31:0]     i_instr,
    output logic [PC_W-1:0] o_pc,
    output logic [31:0]     o_instr,
    output logic            o_valid
);

    logic [PC_W-1:0] r_pc;
    logic [31:0]     r_instr;
    logic            r_valid;

    // Pipeline slot update: reset/flush beats load, load beats hold
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_pc    <= '0;
            r_instr <= NOP_INSTR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_instr <= i_instr;
            r_valid <= 1'b1;
        end
    end

    assign o_pc    = r_pc;
    assign o_instr = r_instr;
    assign o_valid = r_valid;

endmodule : ifid_reg

`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
// ============================================================================
//  Module      : fetch_pc_ctrl
//  Description : Instruction-fetch stage. Owns the PC, drives the
//                instruction-memory address, loads IF/ID and raises the
//                ID/EX flush on taken redirects. Priority in RUN is
//                redirect > stall > sequential; HALTED exits only on reset.
//                Optional macro FETCH_PERF_CNT_EN adds saturating redirect
//                and stall counters; without it both counter outputs are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_ctrl
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             pc_sel,
    input  logic [31:0]      br_pc,
    input  logic             halt_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [31:0]      imem_rdata,
    output logic [PC_W-1:0]  ifid_pc,
    output logic [31:0]      ifid_instr,
    output logic             ifid_valid,
    output logic             flush_idex,
    output logic             halted,
    output logic             misalign_err,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [PC_W-1:0] c_PC_STEP = PC_W'(4);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [PC_W-1:0] r_pc;
    logic            r_misalign;

    logic            w_run;
    logic            w_redirect;
    logic            w_stalled;
    logic            w_advance;
    logic            w_ifid_flush;
    logic            w_ifid_load;
    logic [PC_W-1:0] w_target;
    logic            w_target_bad;

    // Per-cycle action decode; only meaningful while running
    assign w_run      = (r_state == RUN);
    assign w_redirect = w_run & pc_sel;
    assign w_stalled  = w_run & ~pc_sel & stall;
    assign w_advance  = w_run & ~pc_sel & ~stall;

    // Target is forced word aligned and truncated to the PC width
    assign w_target     = {br_pc[PC_W-1:2], 2'b00};
    assign w_target_bad = (br_pc[1:0] != 2'b00) || ((br_pc >> PC_W) != 32'd0);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: halt request parks the FSM until reset
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (halt_req) w_state_next = HALTED;
            HALTED:  w_state_next = HALTED;
            default: w_state_next = RUN;
        endcase
    end

    // Output logic: flush and IF/ID controls derived from state and inputs
    always_comb begin
        halted       = 1'b0;
        flush_idex   = 1'b0;
        w_ifid_flush = 1'b0;
        w_ifid_load  = 1'b0;
        case (r_state)
            RUN: begin
                flush_idex   = pc_sel;
                w_ifid_flush = pc_sel;
                w_ifid_load  = ~pc_sel & ~stall;
            end
            HALTED: begin
                halted       = 1'b1;
                w_ifid_flush = 1'b1;
            end
            default: ;
        endcase
    end

    // Program counter: redirect, sequential advance with natural wrap, or hold
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= w_target;
        end else if (w_advance) begin
            r_pc <= r_pc + c_PC_STEP;
        end
    end

    // Sticky flag for a redirect target that is misaligned or out of range
    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (w_redirect && w_target_bad) begin
            r_misalign <= 1'b1;
        end
    end

    assign imem_addr    = r_pc;
    assign misalign_err = r_misalign;

    ifid_reg #(
        .PC_W (PC_W)
    ) u_ifid_reg (
        .clk     (clk),
        .rst     (reset),
        .i_flush (w_ifid_flush),
        .i_load  (w_ifid_load),
        .i_pc    (r_pc),
        .i_instr (imem_rdata),
        .o_pc    (ifid_pc),
        .o_instr (ifid_instr),
        .o_valid (ifid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] r_redirect_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Saturating event counters for redirects and stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect_cnt <= '0;
            r_stall_cnt    <= '0;
        end else begin
            if (w_redirect && (r_redirect_cnt != '1)) begin
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
            end
            if (w_stalled && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign redirect_cnt = r_redirect_cnt;
    assign stall_cnt    = r_stall_cnt;
`else
    logic w_unused_stalled;
    assign w_unused_stalled = w_stalled;
    assign redirect_cnt     = '0;
    assign stall_cnt        = '0;
`endif

endmodule : fetch_pc_ctrl

`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
// ============================================================================
//  Module      : tb_fetch_pc_ctrl
//  Description : Scoreboard bench for fetch_pc_ctrl. A stimulus process
//                drives directed then random cycles and pushes the expected
//                outputs from a behavioural model; a monitor pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_ctrl;

    localparam int          PC_W     = 9;
    localparam logic [8:0]  RESET_PC = 9'h000;
    localparam int          PC_MOD   = 1 << PC_W;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset, stall, pc_sel, halt_req;
    logic [31:0]      br_pc;
    logic [PC_W-1:0]  imem_addr;
    logic [31:0]      imem_rdata;
    logic [PC_W-1:0]  ifid_pc;
    logic [31:0]      ifid_instr;
    logic             ifid_valid, flush_idex, halted, misalign_err;
    logic [15:0]      redirect_cnt, stall_cnt;

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [PC_W-1:0] a);
        return 32'hC0DE_0000 | 32'(a);
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    fetch_pc_ctrl #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel),
        .br_pc(br_pc), .halt_req(halt_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .ifid_pc(ifid_pc), .ifid_instr(ifid_instr),
        .ifid_valid(ifid_valid), .flush_idex(flush_idex), .halted(halted),
        .misalign_err(misalign_err), .redirect_cnt(redirect_cnt),
        .stall_cnt(stall_cnt)
    );

    typedef struct {
        int unsigned addr, ifpc;
        logic [31:0] instr;
        bit          ifv, flush, halt, mis;
        int unsigned rc, sc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Behavioural model state
    bit          m_known = 0;
    int unsigned m_pc, m_ifpc, m_rc, m_sc;
    logic [31:0] m_instr;
    bit          m_ifv, m_halt, m_mis;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // One clock cycle: drive inputs, predict this cycle's outputs, advance model
    task automatic step(input bit rst_i, input bit st, input bit ps,
                        input logic [31:0] bp, input bit hr);
        exp_t e;
        @(negedge clk);
        reset = rst_i; stall = st; pc_sel = ps; br_pc = bp; halt_req = hr;
        if (m_known) begin
            e.addr  = m_pc;
            e.ifpc  = m_ifpc;
            e.instr = m_instr;
            e.ifv   = m_ifv;
            e.flush = ps && !m_halt;
            e.halt  = m_halt;
            e.mis   = m_mis;
`ifdef FETCH_PERF_CNT_EN
            e.rc    = m_rc;
            e.sc    = m_sc;
`else
            e.rc    = 0;
            e.sc    = 0;
`endif
            q.push_back(e);
        end
        if (rst_i) begin
            m_known = 1; m_pc = RESET_PC; m_ifpc = 0; m_instr = NOP;
            m_ifv = 0; m_halt = 0; m_mis = 0; m_rc = 0; m_sc = 0;
        end else if (m_halt) begin
            m_ifpc = 0; m_instr = NOP; m_ifv = 0;
        end else begin
            if (ps) begin
                m_pc = (bp % PC_MOD) & ~32'd3;
                if ((bp % 4) != 0 || bp >= PC_MOD) m_mis = 1;
                m_ifpc = 0; m_instr = NOP; m_ifv = 0;
                if (m_rc < 65535) m_rc++;
            end else if (st) begin
                if (m_sc < 65535) m_sc++;
            end else begin
                m_ifpc  = m_pc;
                m_instr = 32'hC0DE_0000 + m_pc;
                m_ifv   = 1;
                m_pc    = (m_pc + 4) % PC_MOD;
            end
            if (hr) m_halt = 1;
        end
    endtask

    // Monitor: every cycle the DUT presents a full output set; compare it
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("imem_addr",    32'(imem_addr),    e.addr);
                check("ifid_pc",      32'(ifid_pc),      e.ifpc);
                check("ifid_instr",   ifid_instr,        e.instr);
                check("ifid_valid",   32'(ifid_valid),   32'(e.ifv));
                check("flush_idex",   32'(flush_idex),   32'(e.flush));
                check("halted",       32'(halted),       32'(e.halt));
                check("misalign_err", 32'(misalign_err), 32'(e.mis));
                check("redirect_cnt", 32'(redirect_cnt), e.rc);
                check("stall_cnt",    32'(stall_cnt),    e.sc);
            end
        end
    end

    // Stimulus: directed scenarios followed by randomized traffic
    initial begin
        int unsigned sel;
        logic [31:0] tgt;
        reset = 1; stall = 0; pc_sel = 0; br_pc = 0; halt_req = 0;
        step(1, 0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h040, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h020, 0);
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h100, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h0000_0206, 0);
        repeat (10) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h1F8, 0);
        repeat (3) step(0, 0, 0, 0, 0);
        step(0, 0, 1, 32'h030, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 32'h080, 0);
        step(0, 1, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        step(1, 1, 1, 32'h0C0, 0);
        repeat (2) step(0, 0, 0, 0, 0);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0:       tgt = $urandom_range(0, PC_MOD - 1) & ~32'd3;
                1:       tgt = $urandom_range(0, PC_MOD - 1);
                2:       tgt = $urandom;
                default: tgt = ($urandom_range(0, PC_MOD - 1) & ~32'd3) | 32'h200;
            endcase
            step($urandom_range(0, 79) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 5) == 0,
                 tgt,
                 $urandom_range(0, 49) == 0);
        end
        step(1, 0, 0, 0, 0);
        repeat (2) step(0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #4;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_fetch_pc_ctrl

`default_nettype wire

// File: doc/fetch_pc_ctrl.md
Name: fetch_pc_ctrl

Overview:
- Instruction-fetch stage: owns the program counter, drives instruction-memory address, and loads the IF/ID pipeline register.
- Sits directly downstream of the execute-stage branch unit.
- Consumes its redirect pair (PcSel, BrPC) plus the hazard-unit stall and a halt request.
- Generates the one-cycle ID/EX flush on every taken redirect.

Parameters:
- PC_W, 9, width of PC and instruction-memory byte address.
- RESET_PC, 0, PC value loaded on reset (PC_W bits, word aligned).

Ports:
- clk  input  1  single clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard unit: hold PC and IF/ID
- pc_sel  input  1  branch unit: redirect taken
- br_pc  input  32  branch unit: redirect target (byte address)
- halt_req  input  1  stop fetching (halt instruction decoded)
- imem_addr  output  PC_W  instruction-memory address = current PC
- imem_rdata  input  32  instruction word; combinational read of imem_addr
- ifid_pc  output  PC_W  PC of instruction in IF/ID
- ifid_instr  output  32  instruction in IF/ID
- ifid_valid  output  1  IF/ID holds a real instruction
- flush_idex  output  1  squash ID/EX this cycle
- halted  output  1  FSM in HALTED
- misalign_err  output  1  sticky: redirect target had br_pc[1:0]≠0 or bits above PC_W set
- redirect_cnt  output  16  taken-redirect count (optional feature)
- stall_cnt  output  16  stalled-cycle count (optional feature)

Behaviour:
- Reset is synchronous and active-high and overrides everything. Reset values:
  - pc=RESET_PC, ifid_pc=0, ifid_instr=NOP (32'h0000_0013), ifid_valid=0
  - state=RUN, misalign_err=0, counters=0
- imem_addr = pc, combinational; zero-latency fetch.
- FSM states: RUN, HALTED.
- RUN, per-cycle priority is pc_sel > stall > sequential:
  - pc_sel=1:
    - pc <= {br_pc[PC_W-1:2], 2'b00}.
    - IF/ID <= NOP, valid=0 (wrong-path fetch squashed).
    - flush_idex=1 combinationally in the same cycle.
    - Overrides a simultaneous stall.
    - If br_pc[1:0]≠0 or br_pc[31:PC_W]≠0, set misalign_err; it stays set until reset.
  - stall=1, pc_sel=0: pc and IF/ID hold every bit; flush_idex=0.
  - Otherwise: pc <= pc+4, wrapping modulo 2^PC_W (e.g. 0x1FC → 0x000); IF/ID <= {pc, imem_rdata}, valid=1.
- halt_req=1 in RUN moves to HALTED next cycle. The same-cycle pc_sel/stall/sequential update still applies this cycle.
- HALTED:
  - pc holds; IF/ID forced to NOP, valid=0 every cycle.
  - pc_sel, stall and halt_req are ignored; flush_idex=0.
  - halted=1; exit only via reset.
- flush_idex = pc_sel && state==RUN, with no register stage. It is decoupled from stall.
- Reset asserted mid-redirect or mid-stall: the reset values win; no partial update.
- br_pc bits above PC_W are truncated, and misalign_err is flagged.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - redirect_cnt increments on each RUN cycle with pc_sel=1.
  - stall_cnt increments on each RUN cycle with stall=1 and pc_sel=0.
  - Both saturate at 16'hFFFF and clear on reset.
- Undefined: both outputs tied to 0, no counter flops.

Decomposition:
- Package fetch_pkg holds:
  - NOP_INSTR = 32'h0000_0013
  - fetch_state_t enum {RUN, HALTED}
  - CNT_W = 16
- One natural sub-module, ifid_reg: IF/ID register with load/hold/flush controls. The PC, FSM and counters stay in the top.

Test Plan:
- Reset then 4 free-run cycles, imem returns addr-tagged words → imem_addr 0,4,8,C; ifid_pc lags by one cycle; ifid_valid=1 from cycle 2; flush_idex=0.
- At pc=0x010, pc_sel=1, br_pc=0x040 → next pc=0x040, IF/ID=NOP with valid=0, flush_idex=1 that cycle only, then fetch resumes at 0x044.
- stall=1 for 3 cycles at pc=0x020 → pc and ifid_* constant for 3 cycles; released → pc=0x024.
- stall=1 and pc_sel=1 with br_pc=0x100 in the same cycle → redirect wins: pc=0x100, flush_idex=1.
- pc_sel=1, br_pc=0x0000_0206 → pc=0x004, misalign_err=1 and stays set through 10 normal cycles; pc=0x1FC sequential → wraps to 0x000.
- halt_req=1 at pc=0x030 → halted=1 next cycle, pc frozen at 0x034, ifid_valid=0; later pc_sel=1 ignored; reset → pc=RESET_PC, halted=0.
